// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between instruction fetch and load/store
// Data accesses win over fetches; a fetched word blocked by a stall waits in a one-entry buffer.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  input  logic        stall_in,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        PC_IFWrite,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        stall_mem
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  logic [1:0]  state;
  logic [2:0]  lat_cnt;
  logic        discard;
  logic        buf_full;
  logic [31:0] buf_data;
  logic        d_we_q;

  logic issue_d;
  logic issue_if;
  logic complete;
  logic if_complete;
  logic d_complete;
  logic if_word_live;

  always_comb begin
    issue_d      = (state == IDLE) && d_req;
    issue_if     = (state == IDLE) && !d_req && if_req && !buf_full;
    complete     = (state != IDLE) && (lat_cnt == LAT);
    if_complete  = complete && (state == IF_BUSY);
    d_complete   = complete && (state == D_BUSY);
    if_word_live = if_complete && !discard;
  end

  // Every output is forced low while reset is high so an abandoned access never leaks out.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    if_valid   = 1'b0;
    if_rdata   = 32'd0;
    d_done     = 1'b0;
    d_rdata    = 32'd0;
    stall_mem  = 1'b0;
    PC_IFWrite = 1'b0;
    if (!reset) begin
      if (issue_d) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else if (issue_if) begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      if (buf_full) begin
        if_valid = 1'b1;
        if_rdata = buf_data;
      end else if (if_word_live) begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
      end
      d_done     = d_complete;
      d_rdata    = (d_complete && !d_we_q) ? mem_rdata : 32'd0;
      stall_mem  = d_req && !d_complete;
      PC_IFWrite = if_valid && !stall_in && !stall_mem;
    end
  end

  // lat_cnt reads 1 in the first cycle after issue, so completion lands at issue + MEM_LAT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= 3'd0;
      discard <= 1'b0;
      d_we_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_d) begin
            state   <= D_BUSY;
            lat_cnt <= 3'd1;
            d_we_q  <= d_we;
          end else if (issue_if) begin
            state   <= IF_BUSY;
            lat_cnt <= 3'd1;
            discard <= 1'b0;
          end
        end
        IF_BUSY, D_BUSY: begin
          if (complete) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
            discard <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
            if ((state == IF_BUSY) && if_flush) begin
              discard <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          lat_cnt <= 3'd0;
          discard <= 1'b0;
        end
      endcase
    end
  end

  // A flush in the completion cycle drops the word rather than buffering it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_data <= 32'd0;
    end else if (PC_IFWrite || if_flush) begin
      buf_full <= 1'b0;
    end else if (if_word_live) begin
      buf_full <= 1'b1;
      buf_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        stall_in;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        PC_IFWrite;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        stall_mem;

  mem_port_arbiter #(.MEM_LAT(2)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .stall_in(stall_in), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .if_valid(if_valid), .if_rdata(if_rdata), .PC_IFWrite(PC_IFWrite),
    .d_done(d_done), .d_rdata(d_rdata), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  iss_t        iss_q[$];
  logic [31:0] rd_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic expect_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    iss_q.push_back('{we: we, addr: addr, wdata: wdata});
  endtask

  task automatic check_issue(input string tag);
    iss_t e;
    chk({tag, "_q"}, 32'(iss_q.size() > 0), 32'd1);
    e = (iss_q.size() > 0) ? iss_q.pop_front() : '0;
    chk({tag, "_en"}, 32'(mem_en), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'(e.we));
    chk({tag, "_addr"}, mem_addr, e.addr);
    chk({tag, "_wdata"}, mem_wdata, e.wdata);
  endtask

  task automatic check_if_word(input string tag, input logic pcw);
    logic [31:0] w;
    w = (rd_q.size() > 0) ? rd_q.pop_front() : ~if_rdata;
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_rdata"}, if_rdata, w);
    chk({tag, "_pcw"}, 32'(PC_IFWrite), 32'(pcw));
  endtask

  task automatic check_d_word(input string tag);
    logic [31:0] w;
    w = (rd_q.size() > 0) ? rd_q.pop_front() : ~d_rdata;
    chk({tag, "_done"}, 32'(d_done), 32'd1);
    chk({tag, "_rdata"}, d_rdata, w);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_ifv"}, 32'(if_valid), 32'd0);
    chk({tag, "_pcw"}, 32'(PC_IFWrite), 32'd0);
    chk({tag, "_done"}, 32'(d_done), 32'd0);
    chk({tag, "_stall"}, 32'(stall_mem), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0; stall_in = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = JUNK;

    // Test 1: uncontended fetch, then the next fetch right after completion
    tick(); tick(); smp();
    check_idle_outputs("rst");
    tick(); reset = 1'b0; if_req = 1'b1; if_addr = 32'h0; expect_issue(1'b0, 32'h0, 32'h0);
    smp(); check_issue("t1_iss0");
    tick(); smp(); chk("t1_c1_en", 32'(mem_en), 32'd0);
    tick(); mem_rdata = 32'h2008_0005; rd_q.push_back(32'h2008_0005);
    smp(); check_if_word("t1_c2", 1'b1);
    tick(); mem_rdata = JUNK; if_addr = 32'h4; expect_issue(1'b0, 32'h4, 32'h0);
    smp(); check_issue("t1_iss3");
    tick(); smp();
    tick(); mem_rdata = 32'h0000_0000; rd_q.push_back(32'h0);
    smp(); check_if_word("t1_w2", 1'b1);

    // Test 2: data request beats a simultaneous fetch
    tick(); mem_rdata = JUNK; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; if_addr = 32'h8;
    expect_issue(1'b0, 32'h40, 32'h0);
    smp(); check_issue("t2_iss0"); chk("t2_c0_stall", 32'(stall_mem), 32'd1);
    tick(); smp(); chk("t2_c1_stall", 32'(stall_mem), 32'd1); chk("t2_c1_en", 32'(mem_en), 32'd0);
    tick(); mem_rdata = 32'h1234; rd_q.push_back(32'h1234);
    smp(); check_d_word("t2_c2"); chk("t2_c2_stall", 32'(stall_mem), 32'd0);
    chk("t2_c2_ifv", 32'(if_valid), 32'd0);
    tick(); d_req = 1'b0; mem_rdata = JUNK; expect_issue(1'b0, 32'h8, 32'h0);
    smp(); check_issue("t2_iss3");

    // Test 3: store arrives during the fetch of 0x8
    tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'hCAFE_0001;
    smp(); chk("t3_c1_stall", 32'(stall_mem), 32'd1); chk("t3_c1_en", 32'(mem_en), 32'd0);
    tick(); mem_rdata = 32'h8C02_0000; rd_q.push_back(32'h8C02_0000);
    smp(); check_if_word("t3_c2", 1'b0); chk("t3_c2_done", 32'(d_done), 32'd0);
    tick(); mem_rdata = JUNK; expect_issue(1'b1, 32'h50, 32'hCAFE_0001);
    smp(); check_issue("t3_iss3"); chk("t3_c3_buf", if_rdata, 32'h8C02_0000);
    chk("t3_c3_ifv", 32'(if_valid), 32'd1);
    tick(); smp(); chk("t3_c4_pcw", 32'(PC_IFWrite), 32'd0); chk("t3_c4_buf", if_rdata, 32'h8C02_0000);
    tick(); mem_rdata = 32'h7777_7777; rd_q.push_back(32'h0);
    smp(); check_d_word("t3_c5"); chk("t3_c5_pcw", 32'(PC_IFWrite), 32'd1);
    chk("t3_c5_buf", if_rdata, 32'h8C02_0000); chk("t3_c5_stall", 32'(stall_mem), 32'd0);
    tick(); d_req = 1'b0; d_we = 1'b0; d_wdata = 32'd0; mem_rdata = JUNK; if_addr = 32'h8;
    expect_issue(1'b0, 32'h8, 32'h0);
    smp(); check_issue("t3_iss6");

    // Test 4: flush during the fetch discards its word
    tick(); if_flush = 1'b1;
    smp(); chk("t4_c1_en", 32'(mem_en), 32'd0);
    tick(); if_flush = 1'b0; mem_rdata = 32'h1111_1111;
    smp(); chk("t4_c2_ifv", 32'(if_valid), 32'd0); chk("t4_c2_pcw", 32'(PC_IFWrite), 32'd0);
    tick(); mem_rdata = JUNK; if_addr = 32'h2C; expect_issue(1'b0, 32'h2C, 32'h0);
    smp(); check_issue("t4_iss3");

    // Test 5: stall holds the fetched word in the buffer
    tick(); smp();
    tick(); stall_in = 1'b1; mem_rdata = 32'h03E0_0008; rd_q.push_back(32'h03E0_0008);
    smp(); check_if_word("t5_c2", 1'b0);
    tick(); mem_rdata = JUNK; if_addr = 32'h30;
    for (int c = 3; c <= 4; c++) begin
      smp();
      chk($sformatf("t5_c%0d_ifv", c), 32'(if_valid), 32'd1);
      chk($sformatf("t5_c%0d_rdata", c), if_rdata, 32'h03E0_0008);
      chk($sformatf("t5_c%0d_pcw", c), 32'(PC_IFWrite), 32'd0);
      chk($sformatf("t5_c%0d_en", c), 32'(mem_en), 32'd0);
      tick();
    end
    stall_in = 1'b0;
    smp(); chk("t5_c5_rdata", if_rdata, 32'h03E0_0008); chk("t5_c5_pcw", 32'(PC_IFWrite), 32'd1);
    chk("t5_c5_en", 32'(mem_en), 32'd0);
    tick(); expect_issue(1'b0, 32'h30, 32'h0);
    smp(); check_issue("t5_iss6");
    tick(); if_req = 1'b0;
    tick(); mem_rdata = 32'h2409_000A; rd_q.push_back(32'h2409_000A);
    smp(); check_if_word("t5_dropreq", 1'b1);

    // Test 6: reset in the middle of a load
    tick(); mem_rdata = JUNK; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    expect_issue(1'b0, 32'h60, 32'h0);
    smp(); check_issue("t6_iss0");
    tick(); reset = 1'b1;
    smp(); check_idle_outputs("t6_c1");
    tick(); mem_rdata = 32'h5555_5555;
    smp(); chk("t6_c2_done", 32'(d_done), 32'd0); chk("t6_c2_rdata", d_rdata, 32'd0);
    tick(); reset = 1'b0; mem_rdata = JUNK; expect_issue(1'b0, 32'h60, 32'h0);
    smp(); check_issue("t6_iss3"); chk("t6_c3_stall", 32'(stall_mem), 32'd1);
    tick(); smp();
    tick(); mem_rdata = 32'h6666_0000; rd_q.push_back(32'h6666_0000);
    smp(); check_d_word("t6_ld");
    tick(); d_req = 1'b0;
    smp(); chk("end_iss_q", 32'(iss_q.size()), 32'd0); chk("end_rd_q", 32'(rd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the MIPS pipeline CPU. It generates `PC_IFWrite` for the IF stage and a pipeline-wide `stall_mem`. It sequences fixed-latency memory accesses with one access outstanding at a time. A fetched word that cannot be consumed because of a stall is held in a one-entry buffer.

## Interface
- `MEM_LAT`, default 2: cycles from issue to read data valid; legal range 1..7.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  IF stage requests the instruction at `if_addr`.
- `if_addr`  in  32  fetch address (PC).
- `if_flush`  in  1  branch/jump taken; discard the in-flight or buffered fetch.
- `stall_in`  in  1  hazard-unit stall; IF must not advance.
- `d_req`  in  1  MEM stage access request; held high until `d_done`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `mem_rdata`  in  32  memory read data; valid `MEM_LAT` cycles after issue.
- `mem_en`  out  1  issue strobe, one cycle per access.
- `mem_we`  out  1  write enable; qualified by `mem_en`.
- `mem_addr`  out  32  access address.
- `mem_wdata`  out  32  write data.
- `if_valid`  out  1  `if_rdata` holds a valid instruction.
- `if_rdata`  out  32  fetched instruction.
- `PC_IFWrite`  out  1  IF/PC may advance this cycle.
- `d_done`  out  1  one-cycle completion pulse for the data access.
- `d_rdata`  out  32  load data; 0 for stores.
- `stall_mem`  out  1  data access pending; stalls the whole pipeline.

## Operation
- States:
  - IDLE.
  - IF_BUSY: a fetch is in flight.
  - D_BUSY: a data access is in flight.
- A latency counter runs while the FSM is in a BUSY state.
- Issue happens only from IDLE, combinationally in the same cycle.
  - `d_req` has priority: `mem_en`=1, `mem_we`=`d_we`, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`. The FSM then moves to D_BUSY.
  - Otherwise, if `if_req` is high and the buffer is empty: `mem_en`=1, `mem_we`=0, `mem_addr`=`if_addr`. The FSM then moves to IF_BUSY.
- When not issuing, `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- Completion occurs in cycle T+`MEM_LAT`, where T is the issue cycle. The FSM returns to IDLE at the next edge, so no new issue happens in the completion cycle.
  - D_BUSY completion: `d_done`=1 and `d_rdata`=`mem_rdata` (0 if a store).
  - IF_BUSY completion, not flushed: `if_valid`=1 and `if_rdata`=`mem_rdata`. The word is captured into the buffer at the edge unless it is consumed.
- While the buffer is full, `if_valid`=1 and `if_rdata` is the buffered word, held stable.
- `PC_IFWrite` = `if_valid` & ~`stall_in` & ~`stall_mem`.
- The buffer is cleared at the edge when `PC_IFWrite`=1 or `if_flush`=1.
- `stall_mem` = `d_req` & ~`d_done` (combinational).
- `if_flush` behaviour by state:
  - IF_BUSY: sets a discard flag. At completion `if_valid` is suppressed and the word is dropped.
  - Buffer full: empties the buffer.
  - IDLE: no effect on an issue in the same cycle. The new `if_addr` is the redirect target.
- Deasserting `if_req` mid-fetch has no effect; the fetch completes normally.

## Timing
- Reset state: all outputs 0, IDLE, buffer empty, discard flag clear, counter 0.
- Reset asserted mid-access abandons the access. Its `mem_rdata` is never forwarded, and no `if_valid` or `d_done` appears.
- Throughput is one access per `MEM_LAT`+1 cycles.
- `if_valid`, `PC_IFWrite` and `d_done` are valid in the completion cycle, combinational from `mem_rdata`.
- A fetch is never issued while the buffer is occupied.
- A data request arriving during IF_BUSY waits in D-priority. `stall_mem` is high from the cycle `d_req` rises.

## Test plan
1. Fetch with no contention.
   - Stimulus: reset for 2 cycles, then `if_req`=1, `if_addr`=0x0; memory returns 0x20080005 at cycle 2.
   - Required: `mem_en` in cycle 0; `if_valid`=`PC_IFWrite`=1 with `if_rdata`=0x20080005 in cycle 2; next `mem_en` in cycle 3 with `mem_addr`=0x4.
2. Data priority.
   - Stimulus: `d_req` and `if_req` both rise in IDLE; load from `d_addr`=0x40, memory returns 0x1234.
   - Required: `mem_addr`=0x40 in cycle 0; `stall_mem`=1 in cycles 0–1; `d_done`=1 with `d_rdata`=0x1234 in cycle 2; fetch issued in cycle 3.
3. Contention during a fetch.
   - Stimulus: fetch of 0x8 issued in cycle 0; `d_req` (store, 0x50) rises in cycle 1.
   - Required:
     - Cycle 2: `if_valid`=1, `PC_IFWrite`=0, word buffered.
     - Cycle 3: store issued with `mem_we`=1.
     - Cycle 5: `d_done`=1 and `PC_IFWrite`=1 with the buffered word.
     - Cycle 6: next fetch issued.
4. Flush.
   - Stimulus: `if_flush` pulsed in cycle 1 during a fetch of 0x8.
   - Required: no `if_valid` in cycle 2; cycle 3 issues `if_addr`=0x2C.
5. Stall hold.
   - Stimulus: `stall_in`=1 for cycles 2–4 with a fetch completing in cycle 2.
   - Required: `if_valid`=1 and `if_rdata` stable for cycles 2–5; `PC_IFWrite`=1 only in cycle 5; no `mem_en` until cycle 6.
6. Reset mid-access.
   - Stimulus: `reset` asserted in cycle 1 of a load.
   - Required: all outputs 0 immediately; no `d_done` in cycle 2; a normal issue on the first cycle after release with `d_req` still high.
